// File: rtl/chamada_andar.sv
// chamada_andar: latches elevator floor calls and issues one-hot floor requests using collective scheduling
// clk, reset(active-low, async) | btn[3:0], emerg: raw buttons / emergency stop
// AndarB1, AndarB0: current floor from floor FSM | At, A1, A2, A3: one-hot floor request
// Erro: fault, freezes floor FSM | pend: latched calls (btn order) | dir: scan direction, 1=up
module chamada_andar #(
    parameter int DWELL = 8,
    parameter int TIMEOUT = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       emerg,
    input  logic       AndarB1,
    input  logic       AndarB0,
    output logic       At,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       Erro,
    output logic [3:0] pend,
    output logic       dir
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(DWELL + 1);
    typedef enum logic [1:0] {IDLE, SERVE, DWL, FAULT} state_t;
    state_t state, nxt;
    logic [SYNC_STAGES-1:0][3:0] bsr;
    logic [SYNC_STAGES-1:0] esr;
    logic [3:0] btn_q, rise, set, clr, req, cur_oh;
    logic [1:0] cur, tgt, nxt_tgt, up_t, dn_t;
    logic nxt_dir, up_ok, dn_ok;
    logic [TW-1:0] tcnt;
    logic [DW-1:0] dcnt;
    assign cur = {AndarB1, AndarB0};
    assign cur_oh = 4'b1 << cur;
    assign rise = bsr[SYNC_STAGES-1] & ~btn_q;
    assign {A3, A2, A1, At} = req;
    always_comb begin
        up_ok = 1'b0;
        up_t = '0;
        dn_ok = 1'b0;
        dn_t = '0;
        for (int i = 3; i >= 0; i--) if (i > int'(cur) && pend[i]) begin up_ok = 1'b1; up_t = 2'(i); end
        for (int i = 0; i < 4; i++) if (i < int'(cur) && pend[i]) begin dn_ok = 1'b1; dn_t = 2'(i); end
    end
    always_comb begin
        nxt = state;
        nxt_tgt = tgt;
        nxt_dir = dir;
        clr = '0;
        // door is open while dwelling, so a press at the current floor is dropped
        set = (state == FAULT) ? '0 : rise & ~((state == DWL) ? cur_oh : 4'b0);
        case (state)
            IDLE:
                if (pend[cur]) begin
                    nxt = DWL;
                    clr = cur_oh;
                end else if (|pend) begin
                    nxt = SERVE;
                    nxt_tgt = dir ? (up_ok ? up_t : dn_t) : (dn_ok ? dn_t : up_t);
                    nxt_dir = dir ? up_ok : !dn_ok;
                end
            SERVE:
                if (cur == tgt) begin
                    nxt = DWL;
                    clr = 4'b1 << tgt;
                end else if (tcnt == TW'(TIMEOUT - 1)) nxt = FAULT;
            DWL: nxt = (dcnt == DW'(DWELL - 1)) ? IDLE : DWL;
            default: nxt = FAULT;
        endcase
        if (esr[SYNC_STAGES-1]) nxt = FAULT;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bsr <= '0;
            esr <= '0;
            btn_q <= '0;
            state <= IDLE;
            tgt <= '0;
            dir <= 1'b1;
            pend <= '0;
            req <= '0;
            Erro <= 1'b0;
            tcnt <= '0;
            dcnt <= '0;
        end else begin
            bsr <= {bsr[SYNC_STAGES-2:0], btn};
            esr <= {esr[SYNC_STAGES-2:0], emerg};
            btn_q <= bsr[SYNC_STAGES-1];
            state <= nxt;
            tgt <= nxt_tgt;
            dir <= nxt_dir;
            // clear beats a same-cycle set on the served bit
            pend <= (nxt == FAULT) ? '0 : (pend | set) & ~clr;
            req <= (nxt == SERVE) ? 4'b1 << nxt_tgt : '0;
            Erro <= nxt == FAULT;
            tcnt <= (state == SERVE && nxt == SERVE) ? tcnt + TW'(1) : '0;
            dcnt <= (state == DWL && nxt == DWL) ? dcnt + DW'(1) : '0;
        end
    end
endmodule

// File: tb/tb_chamada_andar.sv
// tb_chamada_andar: directed table plus corner sequences for chamada_andar
module tb_chamada_andar;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] btn = '0;
    logic emerg = 1'b0;
    logic [1:0] cur = '0;
    logic At, A1, A2, A3, Erro, dir;
    logic [3:0] pend;
    logic [9:0] obs;
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct {
        logic [3:0] btn;
        logic [1:0] cur;
        int n;
        logic [9:0] exp;
    } vec_t;
    vec_t tv[32];
    chamada_andar dut (
        .clk(clk), .reset(reset), .btn(btn), .emerg(emerg),
        .AndarB1(cur[1]), .AndarB0(cur[0]),
        .At(At), .A1(A1), .A2(A2), .A3(A3), .Erro(Erro), .pend(pend), .dir(dir)
    );
    always #5 clk = ~clk;
    // {Erro, A3, A2, A1, At, pend[3:0], dir}
    assign obs = {Erro, A3, A2, A1, At, pend, dir};
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (Erro,A3..At,pend,dir)", name, act, exp);
        end
    endtask
    initial begin
        tv[0]  = '{4'b1000, 2'd0, 2,  10'b0_0000_0000_1};
        tv[1]  = '{4'b1000, 2'd0, 1,  10'b0_0000_1000_1};
        tv[2]  = '{4'b0000, 2'd0, 1,  10'b0_1000_1000_1};
        tv[3]  = '{4'b0000, 2'd0, 5,  10'b0_1000_1000_1};
        tv[4]  = '{4'b0000, 2'd3, 1,  10'b0_0000_0000_1};
        tv[5]  = '{4'b0000, 2'd3, 10, 10'b0_0000_0000_1};
        tv[6]  = '{4'b1001, 2'd1, 3,  10'b0_0000_1001_1};
        tv[7]  = '{4'b0000, 2'd1, 1,  10'b0_1000_1001_1};
        tv[8]  = '{4'b0000, 2'd3, 1,  10'b0_0000_0001_1};
        tv[9]  = '{4'b0000, 2'd3, 8,  10'b0_0000_0001_1};
        tv[10] = '{4'b0000, 2'd3, 1,  10'b0_0001_0001_0};
        tv[11] = '{4'b0000, 2'd0, 1,  10'b0_0000_0000_0};
        tv[12] = '{4'b0000, 2'd0, 9,  10'b0_0000_0000_0};
        tv[13] = '{4'b0100, 2'd2, 3,  10'b0_0000_0100_0};
        tv[14] = '{4'b0000, 2'd2, 1,  10'b0_0000_0000_0};
        tv[15] = '{4'b0100, 2'd2, 3,  10'b0_0000_0000_0};
        tv[16] = '{4'b0000, 2'd2, 8,  10'b0_0000_0000_0};
        tv[17] = '{4'b0100, 2'd0, 3,  10'b0_0000_0100_0};
        tv[18] = '{4'b0000, 2'd0, 1,  10'b0_0100_0100_1};
        tv[19] = '{4'b0000, 2'd0, 2,  10'b0_0100_0100_1};
        tv[20] = '{4'b0101, 2'd0, 2,  10'b0_0100_0100_1};
        tv[21] = '{4'b0101, 2'd2, 1,  10'b0_0000_0001_1};
        tv[22] = '{4'b0000, 2'd2, 8,  10'b0_0000_0001_1};
        tv[23] = '{4'b0000, 2'd2, 1,  10'b0_0001_0001_0};
        tv[24] = '{4'b0000, 2'd0, 1,  10'b0_0000_0000_0};
        tv[25] = '{4'b0000, 2'd0, 9,  10'b0_0000_0000_0};
        tv[26] = '{4'b0100, 2'd0, 3,  10'b0_0000_0100_0};
        tv[27] = '{4'b0000, 2'd0, 1,  10'b0_0100_0100_1};
        tv[28] = '{4'b0000, 2'd0, 63, 10'b0_0100_0100_1};
        tv[29] = '{4'b0000, 2'd0, 1,  10'b1_0000_0000_1};
        tv[30] = '{4'b1111, 2'd0, 4,  10'b1_0000_0000_1};
        tv[31] = '{4'b0000, 2'd0, 2,  10'b1_0000_0000_1};
        tick(3);
        chk("reset_state", obs, 10'b0_0000_0000_1);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            btn = tv[i].btn;
            cur = tv[i].cur;
            tick(tv[i].n);
            chk($sformatf("vec%0d", i), obs, tv[i].exp);
        end
        reset = 1'b0;
        #1;
        chk("reset_from_fault", obs, 10'b0_0000_0000_1);
        tick(2);
        reset = 1'b1;
        cur = 2'd0;
        btn = 4'b1000;
        tick(3);
        btn = 4'b0000;
        tick(1);
        chk("serve_a3", obs, 10'b0_1000_1000_1);
        tick(2);
        reset = 1'b0;
        #1;
        chk("reset_mid_serve", obs, 10'b0_0000_0000_1);
        tick(1);
        reset = 1'b1;
        btn = 4'b1000;
        tick(3);
        btn = 4'b0000;
        tick(1);
        chk("serve_a3_again", obs, 10'b0_1000_1000_1);
        emerg = 1'b1;
        tick(2);
        chk("emerg_latency", obs, 10'b0_1000_1000_1);
        tick(1);
        chk("emerg_fault", obs, 10'b1_0000_0000_1);
        emerg = 1'b0;
        btn = 4'b0100;
        tick(5);
        chk("fault_sticky", obs, 10'b1_0000_0000_1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
